pipe_adder_arbiter: RTL and testbench
=====================================

# pipe_adder_arbiter

Round-robin arbiter and scheduler that shares one external pipelined 32-bit ripple-carry adder between two requesters. Each requester presents operands through a valid/ready handshake. The block issues at most one operation per cycle into the adder and tracks each operation's owner through a tag pipeline matched to the adder latency. It returns each sum/carry to the owning requester. It sits between client datapaths and the shared adder instance.

## Interface
Parameters:
- BW, 32: operand/sum width; must equal the adder's width.
- LAT, 4: adder pipeline latency in cycles (1..12); must equal the attached adder's latency.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RESETn  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 operation valid.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  BW  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as the requester 0 ports, for requester 1.
- add_A, add_B  out  BW  operands driven to the adder.
- add_cin  out  1  carry-in driven to the adder.
- add_sum  in  BW  adder sum, valid LAT cycles after inputs.
- add_cout  in  1  adder carry-out.
- resp0_valid, resp1_valid  out  1  one-cycle result strobe per requester.
- resp_sum  out  BW  result sum (shared by both requesters).
- resp_cout  out  1  result carry-out.
- inflight  out  4  operations accepted but not yet responded.

## Operation
- Handshake: an operation transfers when reqN_valid & reqN_ready.
- reqN_ready is combinational from the valid inputs, the round-robin pointer and RESETn. It is 0 while RESETn=0.
- Requesters must hold valid and operands stable until ready.
- Arbitration, at most one grant per cycle:
  - only one requester valid: grant it;
  - both valid: grant the requester not granted most recently.
- Pointer `last` updates only on a grant. Reset value is last=1, so requester 0 wins the first tie.
- Full throughput: a requester alone is granted every cycle. Under contention, grants alternate 0,1,0,1.
- Issue stage (registered):
  - on a grant, add_A/add_B/add_cin load the granted operands;
  - with no grant, these registers hold their previous values;
  - an issue-valid bit and a 1-bit owner tag enter stage 0 of a LAT-deep tag shift register;
  - with no grant, a zero valid bit enters stage 0.
- Return stage (registered):
  - when the tag pipe's last stage is valid, resp_sum<=add_sum and resp_cout<=add_cout;
  - the resp strobe matching the tag pulses 1 for one cycle; the other strobe stays 0;
  - otherwise both strobes are 0 and resp_sum/resp_cout hold.
- No response backpressure: requesters must always accept a response.
- Arithmetic: {resp_cout, resp_sum} = A + B + cin, modulo 2^(BW+1). This is computed by the adder, not the block.
- inflight:
  - increments on a handshake;
  - decrements on any resp strobe;
  - both in the same cycle: unchanged;
  - bounded by LAT+2, so it never wraps.
- Reset (RESETn=0 at an edge):
  - add_A, add_B, add_cin, resp_sum, resp_cout, resp0_valid, resp1_valid, inflight all go to 0;
  - all tag valid bits clear;
  - last = 1.
- Reset mid-operation: in-flight operations are discarded and never produce a strobe. Results the adder emits after reset are ignored.

## Timing
- Handshake at edge t: operands appear on add_* after edge t. The tag enters stage 0 at edge t.
- Adder output for that operation is valid after edge t+LAT. The tag reaches the last stage at the same edge.
- resp strobe, resp_sum and resp_cout are visible after edge t+LAT+1.
- Total latency from accept edge to response: LAT+1 cycles. Responses return in issue order.
- Throughput: one operation per cycle aggregate.
- Tag pipe shifts every cycle; there is no stall.

## Test plan
- Single op, LAT=4: req0 a=30000, b=50000, cin=0, accepted at edge t. Required: resp0_valid=1 only after edge t+5, resp_sum=80000, cout=0, resp1_valid=0, inflight 1 then 0.
- Contention after reset: both valid continuously, distinct operands. Required: grants 0,1,0,1…, strobes alternate in the same order, and every sum matches its own requester's operands.
- Back-to-back: req1 alone, 8 consecutive ops with a=k·30000, b=k·50000. Required: ready=1 every cycle, 8 consecutive resp1 strobes, sums k·80000, peak inflight=LAT+1.
- Wrap/carry: a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1. Then a=b=0xFFFFFFFF, cin=1 → sum=0xFFFFFFFF, cout=1.
- Reset mid-flight: issue 3 ops, assert RESETn=0 for one edge two cycles later. Required: no resp strobes from those ops, inflight=0, add_* = 0, and the next tie is granted to requester 0.
- Idle gaps: requests with random valid gaps. Required: no spurious strobes, add_* hold their values when idle, and inflight returns to 0.

Source files
------------

// File: rtl/pipe_adder_arbiter.sv
// Round-robin scheduler that shares one external pipelined adder between two requesters.
// A tag pipeline matched to the adder latency routes each sum back to the requester that issued it.
module pipe_adder_arbiter #(
    parameter int BW  = 32,
    parameter int LAT = 4
) (
    input  logic          CLK,
    input  logic          RESETn,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [BW-1:0] req0_a,
    input  logic [BW-1:0] req0_b,
    input  logic          req0_cin,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [BW-1:0] req1_a,
    input  logic [BW-1:0] req1_b,
    input  logic          req1_cin,

    output logic [BW-1:0] add_A,
    output logic [BW-1:0] add_B,
    output logic          add_cin,
    input  logic [BW-1:0] add_sum,
    input  logic          add_cout,

    output logic          resp0_valid,
    output logic          resp1_valid,
    output logic [BW-1:0] resp_sum,
    output logic          resp_cout,
    output logic [3:0]    inflight
);

    logic          grant0;
    logic          grant1;
    logic          issue;

    logic          last_q, last_d;
    logic [BW-1:0] add_a_q, add_a_d;
    logic [BW-1:0] add_b_q, add_b_d;
    logic          add_cin_q, add_cin_d;

    logic [LAT:0]  tag_vld_q, tag_vld_d;
    logic [LAT:0]  tag_own_q, tag_own_d;

    logic [BW-1:0] resp_sum_q, resp_sum_d;
    logic          resp_cout_q, resp_cout_d;
    logic          resp0_q, resp0_d;
    logic          resp1_q, resp1_d;
    logic [3:0]    inflight_q, inflight_d;

    // last_q names the requester granted most recently; on a tie the other one wins.
    always_comb begin
        grant0 = RESETn & req0_valid & (~req1_valid | last_q);
        grant1 = RESETn & req1_valid & (~req0_valid | ~last_q);
        issue  = grant0 | grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        last_d    = last_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        if (grant0) begin
            last_d    = 1'b0;
            add_a_d   = req0_a;
            add_b_d   = req0_b;
            add_cin_d = req0_cin;
        end else if (grant1) begin
            last_d    = 1'b1;
            add_a_d   = req1_a;
            add_b_d   = req1_b;
            add_cin_d = req1_cin;
        end
    end

    // Stage 0 is loaded alongside add_*, so stage LAT lines up with the adder output.
    always_comb begin
        tag_vld_d    = '0;
        tag_own_d    = '0;
        tag_vld_d[0] = issue;
        tag_own_d[0] = grant1;
        for (int i = 1; i <= LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
    end

    always_comb begin
        resp_sum_d  = resp_sum_q;
        resp_cout_d = resp_cout_q;
        resp0_d     = 1'b0;
        resp1_d     = 1'b0;
        if (tag_vld_q[LAT]) begin
            resp_sum_d  = add_sum;
            resp_cout_d = add_cout;
            resp0_d     = ~tag_own_q[LAT];
            resp1_d     = tag_own_q[LAT];
        end
    end

    // The count drops on the same edge the strobe appears, so it never exceeds LAT+1.
    always_comb begin
        inflight_d = inflight_q;
        case ({issue, resp0_d | resp1_d})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            last_q      <= 1'b1;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            tag_vld_q   <= '0;
            tag_own_q   <= '0;
            resp_sum_q  <= '0;
            resp_cout_q <= 1'b0;
            resp0_q     <= 1'b0;
            resp1_q     <= 1'b0;
            inflight_q  <= '0;
        end else begin
            last_q      <= last_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            tag_vld_q   <= tag_vld_d;
            tag_own_q   <= tag_own_d;
            resp_sum_q  <= resp_sum_d;
            resp_cout_q <= resp_cout_d;
            resp0_q     <= resp0_d;
            resp1_q     <= resp1_d;
            inflight_q  <= inflight_d;
        end
    end

    assign add_A       = add_a_q;
    assign add_B       = add_b_q;
    assign add_cin     = add_cin_q;
    assign resp_sum    = resp_sum_q;
    assign resp_cout   = resp_cout_q;
    assign resp0_valid = resp0_q;
    assign resp1_valid = resp1_q;
    assign inflight    = inflight_q;

endmodule

// File: tb/tb_pipe_adder_arbiter.sv
// Bench for pipe_adder_arbiter: a pipelined adder stand-in plus a queue-based model of
// accepted operations, compared against the DUT every cycle, with literal spot checks.
module tb_pipe_adder_arbiter;
    localparam int BW  = 32;
    localparam int LAT = 4;

    logic          CLK;
    logic          RESETn;
    logic          req0_valid, req0_ready, req0_cin;
    logic          req1_valid, req1_ready, req1_cin;
    logic [BW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [BW-1:0] add_A, add_B, add_sum, resp_sum;
    logic          add_cin, add_cout;
    logic          resp0_valid, resp1_valid, resp_cout;
    logic [3:0]    inflight;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    pipe_adder_arbiter #(.BW(BW), .LAT(LAT)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .add_A(add_A), .add_B(add_B), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_sum(resp_sum), .resp_cout(resp_cout),
        .inflight(inflight)
    );

    // External adder: result of the operands seen at one edge is on its output LAT edges later.
    logic [BW:0] adder_pipe [LAT];
    always @(posedge CLK) begin
        adder_pipe[0] <= {1'b0, add_A} + {1'b0, add_B} + {{BW{1'b0}}, add_cin};
        for (int i = 1; i < LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
    end
    assign add_cout = adder_pipe[LAT-1][BW];
    assign add_sum  = adder_pipe[LAT-1][BW-1:0];

    // Model: every accepted operation is queued with the cycle its response is due.
    typedef struct {
        int          due;
        bit          owner;
        logic [BW:0] result;
    } exp_t;

    exp_t          exp_q[$];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            peak     = 0;
    int            n_resp0  = 0;
    int            n_resp1  = 0;
    bit            m_last   = 1'b1;
    logic [BW-1:0] m_a      = '0;
    logic [BW-1:0] m_b      = '0;
    logic          m_cin    = 1'b0;
    logic [BW-1:0] m_rsum   = '0;
    logic          m_rcout  = 1'b0;
    bit            g0, g1, act_r0, act_r1, e0, e1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // One full clock cycle: drive, check ready, step the model, check registered outputs.
    task automatic applyStimulus(input bit rst_n,
                                 input bit v0, input logic [BW-1:0] a0, input logic [BW-1:0] b0, input bit c0,
                                 input bit v1, input logic [BW-1:0] a1, input logic [BW-1:0] b1, input bit c1);
        exp_t        r;
        logic [BW:0] res;
        @(negedge CLK);
        RESETn     = rst_n;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
        #1;
        if (!rst_n) begin
            g0 = 1'b0; g1 = 1'b0;
        end else if (v0 && v1) begin
            g0 = m_last; g1 = !m_last;
        end else begin
            g0 = v0; g1 = v1;
        end
        act_r0 = req0_ready;
        act_r1 = req1_ready;
        checkOutput("req0_ready", act_r0, g0);
        checkOutput("req1_ready", act_r1, g1);

        @(posedge CLK);
        cyc++;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            m_last = 1'b1;
            m_a = '0; m_b = '0; m_cin = 1'b0;
            m_rsum = '0; m_rcout = 1'b0;
        end else begin
            if (g0) begin
                res = {1'b0, a0} + {1'b0, b0} + {{BW{1'b0}}, c0};
                m_a = a0; m_b = b0; m_cin = c0; m_last = 1'b0;
                exp_q.push_back('{due: cyc + LAT + 1, owner: 1'b0, result: res});
            end else if (g1) begin
                res = {1'b0, a1} + {1'b0, b1} + {{BW{1'b0}}, c1};
                m_a = a1; m_b = b1; m_cin = c1; m_last = 1'b1;
                exp_q.push_back('{due: cyc + LAT + 1, owner: 1'b1, result: res});
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                r = exp_q.pop_front();
                e0 = !r.owner;
                e1 = r.owner;
                m_rsum  = r.result[BW-1:0];
                m_rcout = r.result[BW];
            end
        end

        #1;
        checkOutput("resp0_valid", resp0_valid, e0);
        checkOutput("resp1_valid", resp1_valid, e1);
        checkOutput("resp_sum", resp_sum, m_rsum);
        checkOutput("resp_cout", resp_cout, m_rcout);
        checkOutput("add_A", add_A, m_a);
        checkOutput("add_B", add_B, m_b);
        checkOutput("add_cin", add_cin, m_cin);
        checkOutput("inflight", inflight, exp_q.size());
        if (int'(inflight) > peak) peak = int'(inflight);
        if (resp0_valid === 1'b1) n_resp0++;
        if (resp1_valid === 1'b1) n_resp1++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Lone operation on an empty pipe with hand-computed sum and carry.
    task automatic runSingle(input bit who, input logic [BW-1:0] a, input logic [BW-1:0] b, input bit cin,
                             input logic [BW-1:0] exp_sum, input bit exp_cout, input string name);
        applyStimulus(1'b1, !who, a, b, cin, who, a, b, cin);
        checkOutput({name, "_accept"}, who ? act_r1 : act_r0, 1);
        checkOutput({name, "_inflight_one"}, inflight, 1);
        for (int k = 1; k <= LAT + 1; k++) begin
            idle(1);
            if (k < LAT + 1) checkOutput({name, "_early_strobe"}, who ? resp1_valid : resp0_valid, 0);
        end
        checkOutput({name, "_strobe"}, who ? resp1_valid : resp0_valid, 1);
        checkOutput({name, "_other_strobe"}, who ? resp0_valid : resp1_valid, 0);
        checkOutput({name, "_sum"}, resp_sum, exp_sum);
        checkOutput({name, "_cout"}, resp_cout, exp_cout);
        checkOutput({name, "_inflight_zero"}, inflight, 0);
    endtask

    initial begin
        int            i0, i1, base0, base1;
        bit            p0, p1, v0, v1, rc0, rc1;
        logic [BW-1:0] ra0, rb0, ra1, rb1;

        RESETn = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd5, 32'd6, 1'b0, 1'b1, 32'd7, 32'd8, 1'b0);
        checkOutput("reset_inflight", inflight, 0);
        checkOutput("reset_add_A", add_A, 0);
        checkOutput("reset_ready0", act_r0, 0);

        runSingle(1'b0, 32'd30000, 32'd50000, 1'b0, 32'd80000, 1'b0, "single");
        runSingle(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "wrap1");
        runSingle(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, "wrap2");

        // Contention straight after reset: grants must go 0,1,0,1...
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b1, 32'(100 + i0), 32'(7 * i0), i0[0],
                                1'b1, 32'(5000 + 3 * i1), 32'(11 * i1), !i1[0]);
            checkOutput("rr_order", act_r0, (k % 2 == 0));
            if (g0) i0++;
            else if (g1) i1++;
        end
        idle(LAT + 2);

        // Back-to-back from requester 1 alone.
        peak  = 0;
        base1 = n_resp1;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 32'(k * 30000), 32'(k * 50000), 1'b0);
            checkOutput("b2b_ready", act_r1, 1);
        end
        idle(LAT + 2);
        checkOutput("b2b_peak_inflight", peak, LAT + 1);
        checkOutput("b2b_strobe_count", n_resp1 - base1, 8);

        // Reset while three operations are in flight.
        base0 = n_resp0;
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 32'(k + 1), 32'(k + 2), 1'b0, 1'b0, '0, '0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("midreset_inflight", inflight, 0);
        checkOutput("midreset_add_A", add_A, 0);
        checkOutput("midreset_add_B", add_B, 0);
        checkOutput("midreset_add_cin", add_cin, 0);
        idle(LAT + 3);
        checkOutput("midreset_no_strobe", n_resp0 - base0, 0);
        applyStimulus(1'b1, 1'b1, 32'd9, 32'd10, 1'b0, 1'b1, 32'd11, 32'd12, 1'b1);
        checkOutput("midreset_tie_to_0", act_r0, 1);
        idle(LAT + 2);

        // Random traffic with gaps; a pending request holds its operands until accepted.
        p0 = 1'b0; p1 = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        ra0 = '0; rb0 = '0; rc0 = 1'b0;
        ra1 = '0; rb1 = '0; rc1 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!p0) begin
                v0  = ($urandom_range(0, 2) == 0);
                ra0 = $urandom; rb0 = $urandom; rc0 = 1'($urandom_range(0, 1));
            end
            if (!p1) begin
                v1  = ($urandom_range(0, 2) == 0);
                ra1 = $urandom; rb1 = $urandom; rc1 = 1'($urandom_range(0, 1));
            end
            applyStimulus(1'b1, v0, ra0, rb0, rc0, v1, ra1, rb1, rc1);
            p0 = v0 && !g0;
            p1 = v1 && !g1;
        end
        idle(LAT + 2);
        checkOutput("gaps_drain_inflight", inflight, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
